// File: rtl/acc_sat_unit.sv
// -----------------------------------------------------------------------------
// acc_sat_unit
//   Sequential signed accumulator. A job starts with a one-cycle start pulse
//   carrying the operand count. Each accepted operand is added to or
//   subtracted from the running sum, and the sum saturates on two's-complement
//   overflow instead of wrapping. When the last operand has been absorbed, the
//   unit presents the sum together with a sticky overflow flag.
//
// Ports
//   clk        system clock, rising-edge
//   reset      synchronous active-high reset, highest priority
//   start      begin a job (sampled only in IDLE)
//   num_ops    operand count for the job (sampled with an accepted start)
//   in_valid   operand valid
//   in_ready   unit accepts an operand this cycle
//   in_data    signed operand
//   in_sub     1: acc - in_data, 0: acc + in_data
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_data   final saturated sum
//   out_ovf    sticky flag: at least one step of the job saturated
//   busy       high in every state except IDLE
//   dbgState   current FSM state (IDLE=0, ACCUM=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Ready never depends on valid; both are decoded from registered state.
// A producer that raises valid holds it and its data until the transfer.
// -----------------------------------------------------------------------------
module acc_sat_unit #(
  parameter int LEN   = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       dbgState
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [LEN-1:0] MAX_VAL = {1'b0, {(LEN-1){1'b1}}};
  localparam logic [LEN-1:0] MIN_VAL = {1'b1, {(LEN-1){1'b0}}};

  logic [1:0]       state;
  logic [LEN-1:0]   acc;
  logic [CNT_W-1:0] count;
  logic             sticky;

  logic [LEN:0]     wideAcc;
  logic [LEN:0]     wideOp;
  logic [LEN:0]     wideSum;
  logic             stepOvf;
  logic [LEN-1:0]   stepRes;
  logic             xfer;

  // One-step arithmetic at LEN+1 bits. With sign-extended operands the
  // LEN-bit result overflowed exactly when the two top bits disagree; this is
  // the same condition as comparing the operand and result signs for add and
  // sub. Saturation direction follows the sign of the accumulator, which on
  // overflow is always the side the true result escaped towards.
  always_comb begin
    wideAcc = {acc[LEN-1], acc};
    wideOp  = {in_data[LEN-1], in_data};
    wideSum = in_sub ? (wideAcc - wideOp) : (wideAcc + wideOp);
    stepOvf = wideSum[LEN] ^ wideSum[LEN-1];
    stepRes = wideSum[LEN-1:0];
    if (stepOvf) begin
      stepRes = acc[LEN-1] ? MIN_VAL : MAX_VAL;
    end
  end

  assign xfer = in_valid && (state == ACCUM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      count  <= '0;
      sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            sticky <= 1'b0;
            count  <= num_ops;
            state  <= (num_ops != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc   <= stepRes;
            count <= count - CNT_W'(1);
            if (stepOvf) begin
              sticky <= 1'b1;
            end
            if (count == CNT_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // acc and sticky are only cleared by a new start, so the last result stays
  // visible on out_data/out_ovf through IDLE.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;
  assign out_ovf   = sticky;
  assign dbgState  = state;

endmodule

// File: doc/acc_sat_unit.md
Name: acc_sat_unit

Overview:
- Sequential signed accumulator that consumes a counted stream of operands and adds or subtracts each one.
- Detects two's-complement overflow on every step and saturates the running sum instead of letting it wrap.
- Reports the final sum with a sticky overflow flag.
- Sits downstream of the ALU add/sub path in the PE datapath: it is the consumer that acts on overflow, where the combinational adder only flags it.

Parameters:
- LEN, 16, data width in bits; signed two's complement.
- CNT_W, 8, width of the operand-count field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a job; sampled only in IDLE.
- num_ops  input  CNT_W  number of operands in the job; sampled together with start.
- in_valid  input  1  operand valid.
- in_ready  output  1  unit accepts an operand this cycle.
- in_data  input  LEN  signed operand.
- in_sub  input  1  per-operand op select: 1 = acc - in_data, 0 = acc + in_data.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  LEN  final saturated sum.
- out_ovf  output  1  sticky flag: at least one step of the job saturated.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: synchronous, active-high. Forces state=IDLE, acc=0, count=0, sticky=0. Outputs after reset: in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0. Reset asserted mid-job discards the job with no output; reset has priority over every other input.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with num_ops!=0 -> ACCUM; acc<=0, sticky<=0, count<=num_ops.
  - start=1 with num_ops==0 -> DONE; acc<=0, sticky<=0.
- ACCUM:
  - in_ready=1 (registered state decode; does not depend on in_valid).
  - A transfer occurs on in_valid&in_ready: acc <= sat(acc +/- in_data), count decrements.
  - No transfer -> all state holds.
  - Transfer with count==1 -> DONE on the next edge.
  - Throughput: one operand per cycle.
- Arithmetic:
  - Compute at LEN+1 bits.
  - Add overflow: acc and in_data have the same sign and the LEN-bit result sign differs from them.
  - Sub overflow: acc and in_data have different signs and the result sign differs from the sign of acc.
  - On overflow: acc <= 2^(LEN-1)-1 when acc[LEN-1]==0, otherwise -2^(LEN-1); sticky <= 1.
  - Saturation is per step. Later steps continue from the saturated value.
- DONE:
  - out_valid=1, out_data=acc, out_ovf=sticky, in_ready=0.
  - Outputs hold stable while out_ready=0.
  - out_valid&out_ready -> IDLE.
  - out_data and out_ovf keep their last value in IDLE until the next start, then go to 0 with the acc/sticky clear.
- Latency: out_valid rises on the cycle after the edge that accepts the final operand.
- start outside IDLE is ignored; num_ops is sampled only on an accepted start.
- Back-to-back jobs: start may be asserted in the first IDLE cycle after the DONE handshake.

Test Plan:
- LEN=16. start, num_ops=3; operands +100 add, +50 sub, -20 add, in_valid held high -> three consecutive transfers; out_valid one cycle after the last; out_data=30, out_ovf=0.
- num_ops=2; 0x7000 add, 0x2000 add -> second step saturates; out_data=0x7FFF, out_ovf=1.
- num_ops=3; 0x8000 add, 1 sub, 5 add -> 0x8000, then saturates at 0x8000, then 0x8005; out_data=0x8005, out_ovf=1 (sticky survives recovery).
- num_ops=0 -> DONE one cycle after start; out_data=0, out_ovf=0. Hold out_ready=0 for 5 cycles -> outputs stable and a second start is ignored.
- in_valid toggling 1,0,0,1 with num_ops=2 -> acc updates only on valid cycles; reset pulsed mid-job with one operand left -> next cycle busy=0, out_valid=0, out_data=0, and no stale result appears afterwards.
